// File: rtl/rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter_if
//  Description : Bundle of the two requester ports and the ROM read pins
//                served by rom_arbiter. The slave modport is the arbiter
//                view; the master modport is the requester/ROM side view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              en;

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              rom_ena;
    logic [ADDR_W-1:0] rom_addra;
    logic [DATA_W-1:0] rom_douta;

    modport slave (
        input  en,
        input  req0, addr0,
        output ack0, rvalid0, rdata0,
        input  req1, addr1,
        output ack1, rvalid1, rdata1,
        output rom_ena, rom_addra,
        input  rom_douta
    );

    modport master (
        output en,
        output req0, addr0,
        input  ack0, rvalid0, rdata0,
        output req1, addr1,
        input  ack1, rvalid1, rdata1,
        input  rom_ena, rom_addra,
        output rom_douta
    );
endinterface
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port ROM.
//                Issues at most one read per cycle, tracks in-flight reads
//                through the fixed ROM latency and returns each word to the
//                port that issued it through a registered response.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1        // ROM latency, 1 or 2 cycles
) (
    input  wire logic    clka,
    input  wire logic    rst,
    rom_arbiter_if.slave bus
);

    // Arbitration result for the current cycle
    logic              w_gnt_vld;
    logic              w_gnt_port;
    logic [ADDR_W-1:0] w_gnt_addr;

    // Port granted most recently; reset to 1 so port 0 wins first contention
    logic              r_last_grant;
    // Address of the last issued read, shown on rom_addra between issues
    logic [ADDR_W-1:0] r_last_addr;

    // In-flight read tracker, one {valid, port} entry per ROM latency cycle
    logic [RD_LAT-1:0] r_stg_vld;
    logic [RD_LAT-1:0] r_stg_port;

    logic              w_ret_vld;
    logic              w_ret_port;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    // Combinational grant: lone requester wins, contention goes to the port
    // that did not win last time; reset and en=0 suppress any issue
    always_comb begin
        w_gnt_vld  = !rst && bus.en && (bus.req0 || bus.req1);
        w_gnt_port = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
        w_gnt_addr = w_gnt_port ? bus.addr1 : bus.addr0;
    end

    assign bus.ack0      = w_gnt_vld & ~w_gnt_port;
    assign bus.ack1      = w_gnt_vld &  w_gnt_port;
    assign bus.rom_ena   = w_gnt_vld;
    assign bus.rom_addra = w_gnt_vld ? w_gnt_addr : r_last_addr;

    // Remember the winner and its address at every issue
    always_ff @(posedge clka) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_last_addr  <= '0;
        end else if (w_gnt_vld) begin
            r_last_grant <= w_gnt_port;
            r_last_addr  <= w_gnt_addr;
        end
    end

    // Stage 0 of the tracker captures each issue; it never stalls
    always_ff @(posedge clka) begin
        if (rst) begin
            r_stg_vld[0]  <= 1'b0;
            r_stg_port[0] <= 1'b0;
        end else begin
            r_stg_vld[0]  <= w_gnt_vld;
            r_stg_port[0] <= w_gnt_port;
        end
    end

    // Remaining stages shift unconditionally so the last stage lines up with
    // the cycle in which rom_douta carries the word
    generate
        for (genvar i = 1; i < RD_LAT; i++) begin : g_stage
            // Advance one tracker entry per cycle
            always_ff @(posedge clka) begin
                if (rst) begin
                    r_stg_vld[i]  <= 1'b0;
                    r_stg_port[i] <= 1'b0;
                end else begin
                    r_stg_vld[i]  <= r_stg_vld[i-1];
                    r_stg_port[i] <= r_stg_port[i-1];
                end
            end
        end
    endgenerate

    assign w_ret_vld  = r_stg_vld[RD_LAT-1];
    assign w_ret_port = r_stg_port[RD_LAT-1];

    // Steer returning ROM data into the issuing port's response register;
    // the other port's data is left untouched
    always_ff @(posedge clka) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_ret_vld & ~w_ret_port;
            r_rvalid1 <= w_ret_vld &  w_ret_port;
            if (w_ret_vld && !w_ret_port) begin
                r_rdata0 <= bus.rom_douta;
            end
            if (w_ret_vld && w_ret_port) begin
                r_rdata1 <= bus.rom_douta;
            end
        end
    end

    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_arbiter
//  Description : Self-checking bench for rom_arbiter. A ROM model answers
//                reads; a reference model predicts grants and queues the
//                expected responses; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic clka;
    logic rst;

    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    // ROM model: word = A500_0000 | address, valid RD_LAT cycles after issue
    logic [DATA_W-1:0] rom_pipe [2];
    always @(posedge clka) begin
        if (bus.rom_ena) rom_pipe[0] <= 32'hA500_0000 | {22'd0, bus.rom_addra};
        rom_pipe[1] <= rom_pipe[0];
    end
    assign bus.rom_douta = (RD_LAT == 1) ? rom_pipe[0] : rom_pipe[1];

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    // Reference model state
    bit          m_last = 1'b1;
    logic [9:0]  m_addr = '0;
    bit          m_vld, m_port;
    bit          m_ack0 = 1'b0, m_ack1 = 1'b0;
    logic [9:0]  m_exp_addr;

    // Arbitration reference: predicts the grant, checks the issue pins and
    // enqueues the response each issued read must produce
    always @(negedge clka) begin
        if (armed) begin
            m_vld  = !rst && bus.en && (bus.req0 || bus.req1);
            m_port = (bus.req0 && bus.req1) ? !m_last : bus.req1;
            m_ack0 = m_vld && !m_port;
            m_ack1 = m_vld &&  m_port;
            check("ack0", {31'd0, bus.ack0}, {31'd0, m_ack0});
            check("ack1", {31'd0, bus.ack1}, {31'd0, m_ack1});
            check("rom_ena", {31'd0, bus.rom_ena}, {31'd0, m_vld});
            m_exp_addr = m_vld ? (m_port ? bus.addr1 : bus.addr0) : m_addr;
            if (!rst) check("rom_addra", {22'd0, bus.rom_addra}, {22'd0, m_exp_addr});
            if (rst) begin
                m_last = 1'b1;
                m_addr = '0;
                while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
            end else if (m_vld) begin
                m_last = m_port;
                m_addr = m_exp_addr;
                q.push_back('{cyc + RD_LAT + 1, m_port, 32'hA500_0000 | {22'd0, m_exp_addr}});
            end
        end else begin
            m_ack0 = 1'b0;
            m_ack1 = 1'b0;
        end
    end

    logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
    bit          ev0, ev1;

    // Response monitor: pops the expected entry due this cycle and checks
    // both rvalid pulses and both held data registers
    always @(negedge clka) begin
        if (armed) begin
            ev0 = 1'b0;
            ev1 = 1'b0;
            if (q.size() > 0 && q[0].due < cyc) begin
                check("lost_resp", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                if (q[0].port) ev1 = 1'b1;
                else           ev0 = 1'b1;
                m_rdata[q[0].port] = q[0].data;
                void'(q.pop_front());
            end
            check("rvalid0", {31'd0, bus.rvalid0}, {31'd0, ev0});
            check("rvalid1", {31'd0, bus.rvalid1}, {31'd0, ev1});
            check("rdata0", bus.rdata0, m_rdata[0]);
            check("rdata1", bus.rdata1, m_rdata[1]);
            if (rst) begin
                m_rdata[0] = '0;
                m_rdata[1] = '0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clka);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (n) next_cycle();
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.addr0 = 10'h010;
        bus.addr1 = 10'h3FF;

        // Reset held two cycles with both ports requesting
        next_cycle();
        armed = 1'b1;
        next_cycle();

        // Contention: grants must alternate starting with port 0
        rst = 1'b0;
        repeat (6) next_cycle();
        idle(4);

        // Single read on port 0
        bus.req0  = 1'b1;
        bus.addr0 = 10'h005;
        next_cycle();
        idle(4);

        // Back-to-back stream on port 1
        for (int i = 0; i < 8; i++) begin
            bus.req1  = 1'b1;
            bus.addr1 = 10'(i);
            next_cycle();
        end
        idle(4);

        // Stream with en low for three cycles in the middle
        bus.req1  = 1'b1;
        bus.addr1 = 10'h100;
        for (int i = 0; i < 12; i++) begin
            bus.en = !(i >= 4 && i < 7);
            next_cycle();
            if (m_ack1) bus.addr1 = bus.addr1 + 10'd1;
        end
        bus.en = 1'b1;
        idle(4);

        // Reset the cycle after a port 0 issue: that read must vanish
        bus.req0  = 1'b1;
        bus.addr0 = 10'h020;
        next_cycle();
        bus.req0 = 1'b0;
        rst      = 1'b1;
        next_cycle();
        rst = 1'b0;
        idle(5);

        // Randomized traffic with enable gaps, abandoned requests and resets
        for (int i = 0; i < 400; i++) begin
            if (bus.req0 && m_ack0) bus.req0 = 1'b0;
            if (bus.req1 && m_ack1) bus.req1 = 1'b0;
            if (!bus.req0) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.req0  = 1'b1;
                    bus.addr0 = 10'($urandom_range(0, 1023));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0 = 1'b0;
            end
            if (!bus.req1) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.req1  = 1'b1;
                    bus.addr1 = 10'($urandom_range(0, 1023));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1 = 1'b0;
            end
            bus.en = ($urandom_range(0, 5) != 0);
            rst    = ($urandom_range(0, 60) == 0);
            next_cycle();
        end
        rst    = 1'b0;
        bus.en = 1'b1;
        idle(6);

        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
